aidc_lite_cfg: RTL and testbench

APB3 slave register block that sits directly upstream of the AIDC Lite compression engine. It holds the job descriptor (source address, destination address, length in 128-byte units) and issues the one-cycle start pulse. It tracks engine busy/done through the engine's level done signal and raises a maskable level interrupt on job completion.

---
 rtl/aidc_lite_cfg_if.sv | 23 ++
 rtl/aidc_lite_cfg.sv | 124 ++++++++++++
 tb/tb_aidc_lite_cfg.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/aidc_lite_cfg_if.sv
// APB3 bus bundle for the AIDC Lite configuration block.
interface aidc_lite_cfg_if #(
  parameter int PADDR_W = 12
);
  logic               psel_i;
  logic               penable_i;
  logic               pwrite_i;
  logic [PADDR_W-1:0] paddr_i;
  logic [31:0]        pwdata_i;
  logic [31:0]        prdata_o;
  logic               pready_o;
  logic               pslverr_o;

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    input  prdata_o, pready_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
    output prdata_o, pready_o, pslverr_o
  );
endinterface

// File: rtl/aidc_lite_cfg.sv
// AIDC Lite APB3 register block: job descriptor, start pulse,
// busy/done tracking from the engine's level done, maskable completion irq.
module aidc_lite_cfg #(
  parameter int          PADDR_W = 12,
  parameter logic [31:0] VERSION = 32'h0001_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  aidc_lite_cfg_if.slave     apb,
  output logic [31:0]        src_addr_o,
  output logic [31:0]        dst_addr_o,
  output logic [24:0]        len_o,
  output logic               start_o,
  input  logic               done_i,
  output logic               irq_o
);
  localparam logic [PADDR_W-1:0] A_VER  = PADDR_W'(32'h000);
  localparam logic [PADDR_W-1:0] A_SRC  = PADDR_W'(32'h100);
  localparam logic [PADDR_W-1:0] A_DST  = PADDR_W'(32'h104);
  localparam logic [PADDR_W-1:0] A_LEN  = PADDR_W'(32'h108);
  localparam logic [PADDR_W-1:0] A_CMD  = PADDR_W'(32'h10C);
  localparam logic [PADDR_W-1:0] A_STAT = PADDR_W'(32'h110);
  localparam logic [PADDR_W-1:0] A_IEN  = PADDR_W'(32'h114);

  logic [31:0] r_src;
  logic [31:0] r_dst;
  logic [24:0] r_len;
  logic        r_busy;
  logic        r_done;
  logic        r_inten;
  logic        r_start;
  logic        r_done_q;
  logic        r_irq;

  logic [PADDR_W-1:0] w_addr;
  logic w_acc, w_wr, w_rd;
  logic w_ver, w_src, w_dst, w_len, w_cmd, w_stat, w_ien, w_mapped;
  logic w_err, w_we, w_start, w_edge;
  logic [31:0] w_rdata;

  // Byte-lane bits of the address are masked off rather than sliced away.
  assign w_addr = apb.paddr_i & ~PADDR_W'(3);
  assign w_acc  = apb.psel_i & apb.penable_i;
  assign w_wr   = w_acc & apb.pwrite_i;
  assign w_rd   = w_acc & ~apb.pwrite_i;

  assign w_ver    = (w_addr == A_VER);
  assign w_src    = (w_addr == A_SRC);
  assign w_dst    = (w_addr == A_DST);
  assign w_len    = (w_addr == A_LEN);
  assign w_cmd    = (w_addr == A_CMD);
  assign w_stat   = (w_addr == A_STAT);
  assign w_ien    = (w_addr == A_IEN);
  assign w_mapped = w_ver | w_src | w_dst | w_len | w_cmd | w_stat | w_ien;

  // Descriptor/CMD writes are locked while a job runs so the engine sees stable inputs.
  assign w_err = w_acc & (~w_mapped |
                 (apb.pwrite_i & (((w_src | w_dst | w_len | w_cmd) & r_busy) |
                                  w_ver | (w_stat & apb.pwdata_i[0]))));
  assign w_we    = w_wr & ~w_err;
  assign w_start = w_we & w_cmd & apb.pwdata_i[0];
  assign w_edge  = r_busy & done_i & ~r_done_q;

  // Read data mux, only driven during a read access phase.
  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (w_addr)
        A_VER:   w_rdata = VERSION;
        A_SRC:   w_rdata = r_src;
        A_DST:   w_rdata = r_dst;
        A_LEN:   w_rdata = {r_len, 7'b0};
        A_STAT:  w_rdata = {30'b0, r_done, r_busy};
        A_IEN:   w_rdata = {31'b0, r_inten};
        default: w_rdata = '0;
      endcase
    end
  end

  // Descriptor and interrupt-enable registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_inten <= 1'b0;
    end else if (w_we) begin
      if (w_src) r_src   <= apb.pwdata_i;
      if (w_dst) r_dst   <= apb.pwdata_i;
      if (w_len) r_len   <= apb.pwdata_i[31:7];
      if (w_ien) r_inten <= apb.pwdata_i[0];
    end
  end

  // Job control: start pulse, busy/done tracking on done_i rising edge, irq.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_start  <= 1'b0;
      r_done_q <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_done_q <= done_i;
      r_start  <= w_start;
      r_irq    <= r_done & r_inten;
      if (w_start)     r_busy <= 1'b1;
      else if (w_edge) r_busy <= 1'b0;
      // Done edge takes priority over a same-cycle W1C.
      if (w_edge)                                 r_done <= 1'b1;
      else if (w_start)                           r_done <= 1'b0;
      else if (w_we & w_stat & apb.pwdata_i[1])   r_done <= 1'b0;
    end
  end

  assign apb.prdata_o  = w_rdata;
  assign apb.pready_o  = 1'b1;
  assign apb.pslverr_o = w_err;
  assign src_addr_o    = r_src;
  assign dst_addr_o    = r_dst;
  assign len_o         = r_len;
  assign start_o       = r_start;
  assign irq_o         = r_irq;
endmodule

// File: tb/tb_aidc_lite_cfg.sv
// Directed bench for aidc_lite_cfg: register vector table plus job sequences.
module tb_aidc_lite_cfg;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] src_addr_o, dst_addr_o;
  logic [24:0] len_o;
  logic        start_o, done_i, irq_o;

  int n_vec = 0;
  int n_mis = 0;
  int n_start = 0;

  aidc_lite_cfg_if #(.PADDR_W(12)) apb_if ();

  aidc_lite_cfg #(.PADDR_W(12), .VERSION(32'h0001_0000)) dut (
    .clk(clk), .rst_n(rst_n), .apb(apb_if.slave),
    .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o), .len_o(len_o),
    .start_o(start_o), .done_i(done_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (start_o) n_start++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vt[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called at posedge+1; setup phase, access phase, commits on the following edge.
  task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic er);
    apb_if.psel_i    = 1'b1;
    apb_if.penable_i = 1'b0;
    apb_if.pwrite_i  = wr;
    apb_if.paddr_i   = a;
    apb_if.pwdata_i  = d;
    @(posedge clk); #1;
    apb_if.penable_i = 1'b1;
    #1;
    rd = apb_if.prdata_o;
    er = apb_if.pslverr_o;
    @(posedge clk); #1;
    apb_if.psel_i    = 1'b0;
    apb_if.penable_i = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          s0;

  initial begin
    vt[0]  = '{1'b0, 12'h000, 32'h0,         32'h0001_0000, 1'b0, "rd_version"};
    vt[1]  = '{1'b0, 12'h100, 32'h0,         32'h0,         1'b0, "rd_src_rst"};
    vt[2]  = '{1'b0, 12'h108, 32'h0,         32'h0,         1'b0, "rd_len_rst"};
    vt[3]  = '{1'b0, 12'h110, 32'h0,         32'h0,         1'b0, "rd_status_rst"};
    vt[4]  = '{1'b1, 12'h100, 32'h1000_0000, 32'h0,         1'b0, "wr_src"};
    vt[5]  = '{1'b1, 12'h104, 32'h2000_0000, 32'h0,         1'b0, "wr_dst"};
    vt[6]  = '{1'b1, 12'h108, 32'h0000_1FFF, 32'h0,         1'b0, "wr_len"};
    vt[7]  = '{1'b0, 12'h100, 32'h0,         32'h1000_0000, 1'b0, "rd_src"};
    vt[8]  = '{1'b0, 12'h105, 32'h0,         32'h2000_0000, 1'b0, "rd_dst_lowbits"};
    vt[9]  = '{1'b0, 12'h108, 32'h0,         32'h0000_1F80, 1'b0, "rd_len"};
    vt[10] = '{1'b1, 12'h114, 32'h0000_0001, 32'h0,         1'b0, "wr_inten"};
    vt[11] = '{1'b0, 12'h114, 32'h0,         32'h0000_0001, 1'b0, "rd_inten"};
    vt[12] = '{1'b0, 12'h10C, 32'h0,         32'h0,         1'b0, "rd_cmd"};
    vt[13] = '{1'b1, 12'h10C, 32'h0,         32'h0,         1'b0, "wr_cmd0"};
    vt[14] = '{1'b0, 12'h110, 32'h0,         32'h0,         1'b0, "rd_status_idle"};
    vt[15] = '{1'b0, 12'h050, 32'h0,         32'h0,         1'b1, "rd_unmapped"};
    vt[16] = '{1'b1, 12'h000, 32'h0000_1234, 32'h0,         1'b1, "wr_version"};
    vt[17] = '{1'b0, 12'h000, 32'h0,         32'h0001_0000, 1'b0, "rd_version2"};
    vt[18] = '{1'b1, 12'h200, 32'h0000_5555, 32'h0,         1'b1, "wr_unmapped"};

    apb_if.psel_i = 1'b0; apb_if.penable_i = 1'b0; apb_if.pwrite_i = 1'b0;
    apb_if.paddr_i = '0;  apb_if.pwdata_i = '0;
    done_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_start", {31'b0, start_o}, 32'h0);
    chk("rst_irq",   {31'b0, irq_o},   32'h0);
    chk("idle_prdata", apb_if.prdata_o, 32'h0);

    for (int i = 0; i < 19; i++) begin
      apb(vt[i].wr, vt[i].addr, vt[i].wdata, rd, er);
      if (!vt[i].wr) chk({vt[i].name, "_rd"}, rd, vt[i].exp_rd);
      chk({vt[i].name, "_err"}, {31'b0, er}, {31'b0, vt[i].exp_err});
    end

    chk("src_out", src_addr_o, 32'h1000_0000);
    chk("dst_out", dst_addr_o, 32'h2000_0000);
    chk("len_out", {7'b0, len_o}, 32'h0000_003F);
    chk("no_start_yet", n_start, 0);

    // Job 1: start pulse, done after 10 low cycles, irq, W1C.
    apb(1'b1, 12'h10C, 32'h1, rd, er);
    chk("start_hi", {31'b0, start_o}, 32'h1);
    cyc(1);
    chk("start_lo", {31'b0, start_o}, 32'h0);
    apb(1'b0, 12'h110, 32'h0, rd, er);
    chk("status_busy", rd, 32'h1);
    cyc(10);
    done_i = 1'b1;
    cyc(1);
    chk("irq_lag", {31'b0, irq_o}, 32'h0);
    cyc(1);
    chk("irq_set", {31'b0, irq_o}, 32'h1);
    apb(1'b0, 12'h110, 32'h0, rd, er);
    chk("status_done", rd, 32'h2);
    chk("one_pulse", n_start, 1);
    apb(1'b1, 12'h110, 32'h2, rd, er);
    chk("w1c_err", {31'b0, er}, 32'h0);
    cyc(1);
    chk("irq_clr", {31'b0, irq_o}, 32'h0);
    apb(1'b0, 12'h110, 32'h0, rd, er);
    chk("status_clr", rd, 32'h0);

    // Job 2 with done_i still high: writes blocked, stale done ignored.
    apb(1'b1, 12'h10C, 32'h1, rd, er);
    apb(1'b1, 12'h100, 32'hDEAD_BEEF, rd, er);
    chk("busy_wr_src_err", {31'b0, er}, 32'h1);
    apb(1'b1, 12'h10C, 32'h1, rd, er);
    chk("busy_wr_cmd_err", {31'b0, er}, 32'h1);
    apb(1'b1, 12'h108, 32'hFFFF_FFFF, rd, er);
    chk("busy_wr_len_err", {31'b0, er}, 32'h1);
    apb(1'b1, 12'h114, 32'h1, rd, er);
    chk("busy_wr_ien_ok", {31'b0, er}, 32'h0);
    apb(1'b0, 12'h100, 32'h0, rd, er);
    chk("src_kept", rd, 32'h1000_0000);
    chk("len_kept", {7'b0, len_o}, 32'h0000_003F);
    cyc(5);
    apb(1'b0, 12'h110, 32'h0, rd, er);
    chk("stale_done_busy", rd, 32'h1);
    chk("two_pulses", n_start, 2);
    done_i = 1'b0;
    cyc(2);
    apb(1'b0, 12'h110, 32'h0, rd, er);
    chk("done_low_busy", rd, 32'h1);
    done_i = 1'b1;
    cyc(2);
    apb(1'b0, 12'h110, 32'h0, rd, er);
    chk("job2_done", rd, 32'h2);

    // Done edge while idle is ignored.
    apb(1'b1, 12'h110, 32'h2, rd, er);
    done_i = 1'b0;
    cyc(2);
    done_i = 1'b1;
    cyc(2);
    apb(1'b0, 12'h110, 32'h0, rd, er);
    chk("idle_edge_ignored", rd, 32'h0);
    apb(1'b1, 12'h110, 32'h1, rd, er);
    chk("wr_busy_bit_err", {31'b0, er}, 32'h1);

    // Async reset with DONE/irq set clears irq immediately.
    done_i = 1'b0;
    apb(1'b1, 12'h10C, 32'h1, rd, er);
    cyc(2);
    done_i = 1'b1;
    cyc(2);
    chk("irq_before_rst", {31'b0, irq_o}, 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("irq_async_clr", {31'b0, irq_o}, 32'h0);
    cyc(1);
    rst_n = 1'b1;

    // Async reset right after start drops start_o and BUSY.
    s0 = n_start;
    done_i = 1'b0;
    apb(1'b1, 12'h10C, 32'h1, rd, er);
    chk("start_before_rst", {31'b0, start_o}, 32'h1);
    rst_n = 1'b0;
    #1 chk("start_async_clr", {31'b0, start_o}, 32'h0);
    cyc(1);
    apb(1'b0, 12'h110, 32'h0, rd, er);
    chk("status_in_rst", rd, 32'h0);
    apb(1'b0, 12'h100, 32'h0, rd, er);
    chk("src_in_rst", rd, 32'h0);
    chk("no_pulse_in_rst", n_start, s0);
    rst_n = 1'b1;
    cyc(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
